// File: rtl/turn_arbiter_if.sv
// turn_arbiter_if: board/player/computer handshake bundle for the turn arbiter
interface turn_arbiter_if #(parameter int SCORE_W = 4);
    logic               start;
    logic               first_pc;
    logic               pl_req;
    logic [3:0]         pl_pos;
    logic               pc_req;
    logic [3:0]         pc_pos;
    logic               illegal;
    logic               win;
    logic [1:0]         who;
    logic               no_space;
    logic               pl_ack;
    logic               pc_ack;
    logic               pl_nak;
    logic               pc_nak;
    logic               move_en;
    logic [3:0]         move_pos;
    logic [1:0]         move_who;
    logic [1:0]         turn;
    logic               game_over;
    logic [1:0]         result;
    logic               timeout;
    logic [SCORE_W-1:0] pl_score;
    logic [SCORE_W-1:0] pc_score;

    modport master (
        output start, first_pc, pl_req, pl_pos, pc_req, pc_pos, illegal, win, who, no_space,
        input  pl_ack, pc_ack, pl_nak, pc_nak, move_en, move_pos, move_who, turn,
               game_over, result, timeout, pl_score, pc_score
    );

    modport slave (
        input  start, first_pc, pl_req, pl_pos, pc_req, pc_pos, illegal, win, who, no_space,
        output pl_ack, pc_ack, pl_nak, pc_nak, move_en, move_pos, move_who, turn,
               game_over, result, timeout, pl_score, pc_score
    );
endinterface

// File: rtl/turn_arbiter.sv
// turn_arbiter: alternates player/computer turns, strobes moves to the board, tracks result and scores
module turn_arbiter #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int SCORE_W     = 4
) (
    input logic           clock,
    input logic           reset,
    turn_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_PL, WAIT_PC, STROBE, CHECK, OVER} state_t;

    localparam logic [15:0]        RELOAD = 16'(TIMEOUT_CYC - 1);
    localparam logic [SCORE_W-1:0] MAX    = '1;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [3:0]         pos_q, pos_d;
    logic [1:0]         who_q, who_d;
    logic [1:0]         result_q, result_d;
    logic               timeout_q, timeout_d;
    logic [SCORE_W-1:0] pl_score_q, pl_score_d;
    logic [SCORE_W-1:0] pc_score_q, pc_score_d;
    logic               is_pl, req, strobe, pl_mover;

    assign is_pl    = state_q == WAIT_PL;
    assign req      = is_pl ? bus.pl_req : bus.pc_req;
    assign strobe   = state_q == STROBE;
    assign pl_mover = who_q == 2'b01;

    // next-state: the timeout counter only reloads on entry to a WAIT state, so an illegal retry keeps its deadline
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        who_d      = who_q;
        result_d   = result_q;
        timeout_d  = 1'b0;
        pl_score_d = pl_score_q;
        pc_score_d = pc_score_q;
        case (state_q)
            IDLE, OVER: if (bus.start) begin
                state_d  = bus.first_pc ? WAIT_PC : WAIT_PL;
                cnt_d    = RELOAD;
                result_d = 2'b00;
            end
            WAIT_PL, WAIT_PC: if (req) begin
                state_d = STROBE;
                pos_d   = is_pl ? bus.pl_pos : bus.pc_pos;
                who_d   = is_pl ? 2'b01 : 2'b10;
            end else if (cnt_q == 16'd0) begin
                state_d   = is_pl ? WAIT_PC : WAIT_PL;
                cnt_d     = RELOAD;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            STROBE: state_d = !bus.illegal ? CHECK : pl_mover ? WAIT_PL : WAIT_PC;
            CHECK: if (bus.win) begin
                state_d    = OVER;
                result_d   = bus.who;
                pl_score_d = (bus.who == 2'b01 && pl_score_q != MAX) ? pl_score_q + SCORE_W'(1) : pl_score_q;
                pc_score_d = (bus.who == 2'b10 && pc_score_q != MAX) ? pc_score_q + SCORE_W'(1) : pc_score_q;
            end else if (bus.no_space) begin
                state_d  = OVER;
                result_d = 2'b11;
            end else begin
                state_d = pl_mover ? WAIT_PC : WAIT_PL;
                cnt_d   = RELOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; reset discards any in-flight move
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= RELOAD;
            pos_q      <= 4'd0;
            who_q      <= 2'b00;
            result_q   <= 2'b00;
            timeout_q  <= 1'b0;
            pl_score_q <= '0;
            pc_score_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            who_q      <= who_d;
            result_q   <= result_d;
            timeout_q  <= timeout_d;
            pl_score_q <= pl_score_d;
            pc_score_q <= pc_score_d;
        end
    end

    assign bus.turn      = is_pl ? 2'b01 : state_q == WAIT_PC ? 2'b10 : 2'b00;
    assign bus.move_en   = strobe;
    assign bus.move_pos  = pos_q;
    assign bus.move_who  = who_q;
    assign bus.pl_ack    = strobe && pl_mover && !bus.illegal;
    assign bus.pl_nak    = strobe && pl_mover && bus.illegal;
    assign bus.pc_ack    = strobe && !pl_mover && !bus.illegal;
    assign bus.pc_nak    = strobe && !pl_mover && bus.illegal;
    assign bus.game_over = state_q == OVER;
    assign bus.result    = result_q;
    assign bus.timeout   = timeout_q;
    assign bus.pl_score  = pl_score_q;
    assign bus.pc_score  = pc_score_q;
endmodule

// File: tb/tb_turn_arbiter.sv
// tb_turn_arbiter: scenario tasks with a move scoreboard checked at each board strobe
module tb_turn_arbiter;
    localparam int TO = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [1:0] who;
        logic [3:0] pos;
        logic       nak;
    } mv_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    mv_t  sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    turn_arbiter_if #(.SCORE_W(SW)) bus();

    turn_arbiter #(.TIMEOUT_CYC(TO), .SCORE_W(SW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.first_pc = 0; bus.pl_req = 0; bus.pl_pos = 0;
        bus.pc_req = 0; bus.pc_pos = 0; bus.illegal = 0; bus.win = 0;
        bus.who = 0; bus.no_space = 0;
    endtask

    task automatic begin_game(input logic pc_first);
        logic [1:0] exp_turn;
        exp_turn = pc_first ? 2'b10 : 2'b01;
        bus.start = 1; bus.first_pc = pc_first;
        tick();
        bus.start = 0; bus.first_pc = 0;
        n_checks++;
        if ({bus.turn, bus.result, bus.game_over} !== {exp_turn, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL start_state got turn/result/over %b/%b/%b exp %b/00/0", bus.turn, bus.result, bus.game_over, exp_turn);
        end
    endtask

    task automatic move(input logic pc_side, input logic [3:0] pos, input logic ill,
                        input logic w, input logic [1:0] wh, input logic ns);
        mv_t e, got;
        logic [3:0] exp_hs;
        e.who = pc_side ? 2'b10 : 2'b01;
        e.pos = pos;
        e.nak = ill;
        sb.push_back(e);
        exp_hs = pc_side ? {2'b00, !ill, ill} : {!ill, ill, 2'b00};
        if (pc_side) begin bus.pc_req = 1; bus.pc_pos = pos; end
        else begin bus.pl_req = 1; bus.pl_pos = pos; end
        tick();
        bus.pl_req = 0; bus.pc_req = 0; bus.illegal = ill;
        @(negedge clock);
        n_checks++;
        if ({bus.move_en, bus.timeout, bus.turn} !== 4'b1000) begin
            n_fail++;
            $display("FAIL strobe_state got en/to/turn %b/%b/%b exp 1/0/00", bus.move_en, bus.timeout, bus.turn);
        end
        got.who = bus.move_who;
        got.pos = bus.move_pos;
        got.nak = pc_side ? bus.pc_nak : bus.pl_nak;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty got %h", got);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL strobe_move got who/pos/nak %h exp %h", got, e);
            end
        end
        n_checks++;
        if ({bus.pl_ack, bus.pl_nak, bus.pc_ack, bus.pc_nak} !== exp_hs) begin
            n_fail++;
            $display("FAIL handshake got %b exp %b", {bus.pl_ack, bus.pl_nak, bus.pc_ack, bus.pc_nak}, exp_hs);
        end
        tick();
        bus.illegal = 0;
        if (!ill) begin
            bus.win = w; bus.who = wh; bus.no_space = ns;
            @(negedge clock);
            n_checks++;
            if ({bus.move_en, bus.turn} !== 3'b000) begin
                n_fail++;
                $display("FAIL check_state got en/turn %b/%b exp 0/00", bus.move_en, bus.turn);
            end
            tick();
            bus.win = 0; bus.who = 0; bus.no_space = 0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        n_checks++;
        if ({bus.turn, bus.result, bus.move_pos, bus.move_who, bus.pl_score, bus.pc_score} !== '0) begin
            n_fail++;
            $display("FAIL reset_values got turn %b result %b pos %h who %b scores %0d/%0d exp all 0",
                     bus.turn, bus.result, bus.move_pos, bus.move_who, bus.pl_score, bus.pc_score);
        end
        n_checks++;
        if ({bus.move_en, bus.timeout, bus.game_over, bus.pl_ack, bus.pl_nak, bus.pc_ack, bus.pc_nak} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_pulses got %b exp 0000000",
                     {bus.move_en, bus.timeout, bus.game_over, bus.pl_ack, bus.pl_nak, bus.pc_ack, bus.pc_nak});
        end
    endtask

    task automatic test_player_win();
        begin_game(0);
        bus.pc_req = 1; bus.pc_pos = 1;
        @(negedge clock);
        n_checks++;
        if ({bus.pc_ack, bus.pc_nak, bus.move_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL pc_ignored got ack/nak/en %b exp 000", {bus.pc_ack, bus.pc_nak, bus.move_en});
        end
        tick();
        bus.pc_req = 0;
        n_checks++;
        if ({bus.move_en, bus.turn} !== 3'b001) begin
            n_fail++;
            $display("FAIL pc_ignored_turn got en/turn %b/%b exp 0/01", bus.move_en, bus.turn);
        end
        move(0, 5, 0, 0, 2'b00, 0);
        n_checks++;
        if (bus.turn !== 2'b10) begin
            n_fail++;
            $display("FAIL turn_after_pl got %b exp 10", bus.turn);
        end
        move(1, 1, 0, 0, 2'b00, 0);
        move(0, 3, 0, 0, 2'b00, 0);
        move(1, 2, 0, 0, 2'b00, 0);
        move(0, 7, 0, 1, 2'b01, 0);
        n_checks++;
        if ({bus.game_over, bus.result, bus.pl_score, bus.pc_score, bus.turn} !== {1'b1, 2'b01, 2'd1, 2'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL player_win got over %b result %b scores %0d/%0d turn %b exp 1 01 1/0 00",
                     bus.game_over, bus.result, bus.pl_score, bus.pc_score, bus.turn);
        end
        bus.pl_req = 1; bus.pl_pos = 4;
        tick();
        bus.pl_req = 0;
        n_checks++;
        if ({bus.move_en, bus.game_over} !== 2'b01) begin
            n_fail++;
            $display("FAIL over_ignores_req got en/over %b/%b exp 0/1", bus.move_en, bus.game_over);
        end
    endtask

    task automatic test_illegal();
        begin_game(0);
        move(0, 5, 1, 0, 2'b00, 0);
        n_checks++;
        if (bus.turn !== 2'b01) begin
            n_fail++;
            $display("FAIL turn_after_nak got %b exp 01", bus.turn);
        end
        move(0, 6, 0, 0, 2'b00, 0);
        n_checks++;
        if (bus.turn !== 2'b10) begin
            n_fail++;
            $display("FAIL turn_after_retry got %b exp 10", bus.turn);
        end
    endtask

    task automatic test_timeout();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.timeout !== 1'b1 && k < 20);
        n_checks++;
        if (k != TO || bus.turn !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_pass got cycles %0d turn %b exp %0d 01", k, bus.turn, TO);
        end
        tick();
        n_checks++;
        if (bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_single got %b exp 0", bus.timeout);
        end
        tick();
        tick();
        move(0, 4, 0, 0, 2'b00, 0);
        n_checks++;
        if (bus.turn !== 2'b10) begin
            n_fail++;
            $display("FAIL req_beats_timeout turn got %b exp 10", bus.turn);
        end
    endtask

    task automatic test_draw();
        logic [3:0] pos_tab [7] = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd5};
        for (int i = 0; i < 7; i++) move(i % 2 == 0, pos_tab[i], 0, 0, 2'b00, i == 6);
        n_checks++;
        if ({bus.game_over, bus.result, bus.pl_score, bus.pc_score} !== {1'b1, 2'b11, 2'd1, 2'd0}) begin
            n_fail++;
            $display("FAIL draw got over %b result %b scores %0d/%0d exp 1 11 1/0",
                     bus.game_over, bus.result, bus.pl_score, bus.pc_score);
        end
    endtask

    task automatic test_win_priority();
        begin_game(1);
        move(1, 5, 0, 1, 2'b10, 1);
        n_checks++;
        if ({bus.result, bus.pl_score, bus.pc_score} !== {2'b10, 2'd1, 2'd1}) begin
            n_fail++;
            $display("FAIL win_priority got result %b scores %0d/%0d exp 10 1/1", bus.result, bus.pl_score, bus.pc_score);
        end
    endtask

    task automatic test_saturation();
        logic [SW-1:0] exp_s;
        reset = 1;
        tick();
        reset = 0;
        n_checks++;
        if ({bus.pl_score, bus.pc_score} !== '0) begin
            n_fail++;
            $display("FAIL score_reset got %0d/%0d exp 0/0", bus.pl_score, bus.pc_score);
        end
        for (int k = 1; k <= 4; k++) begin
            exp_s = (k < 3) ? SW'(k) : SW'(3);
            begin_game(0);
            move(0, 5, 0, 1, 2'b01, 0);
            n_checks++;
            if (bus.pl_score !== exp_s) begin
                n_fail++;
                $display("FAIL saturation win %0d got %0d exp %0d", k, bus.pl_score, exp_s);
            end
        end
    endtask

    task automatic test_reset_strobe();
        begin_game(1);
        bus.pc_req = 1; bus.pc_pos = 9;
        tick();
        bus.pc_req = 0;
        n_checks++;
        if (bus.move_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_strobe_setup got en %b exp 1", bus.move_en);
        end
        reset = 1;
        tick();
        reset = 0;
        n_checks++;
        if ({bus.move_en, bus.pc_ack, bus.pc_nak, bus.timeout, bus.game_over, bus.turn, bus.result,
             bus.move_pos, bus.move_who, bus.pl_score, bus.pc_score} !== '0) begin
            n_fail++;
            $display("FAIL rst_in_strobe got en %b ack %b turn %b pos %h who %b scores %0d/%0d exp all 0",
                     bus.move_en, bus.pc_ack, bus.turn, bus.move_pos, bus.move_who, bus.pl_score, bus.pc_score);
        end
        tick();
        n_checks++;
        if ({bus.move_en, bus.turn} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_stays_idle got en/turn %b/%b exp 0/00", bus.move_en, bus.turn);
        end
        begin_game(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_player_win();
        test_illegal();
        test_timeout();
        test_draw();
        test_win_priority();
        test_saturation();
        test_reset_strobe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/turn_arbiter.md
TURN_ARBITER -- requirements
Module: turn_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1000: cycles a side may hold its turn before forfeiting it (legal range 2..65535).
REQ-002 Parameter SCORE_W, default 4: width of each win counter.
REQ-003 clock  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  level; begins a new game when sampled in IDLE or OVER.
REQ-006 first_pc  in  1  sampled with start; 1 = computer moves first.
REQ-007 pl_req / pl_pos  in  1 / 4  player move request and position (1..9).
REQ-008 pc_req / pc_pos  in  1 / 4  computer move request and position (1..9).
REQ-009 illegal  in  1  board's combinational illegal-move flag for the strobed move, valid in the strobe cycle.
REQ-010 win / who / no_space  in  1 / 2 / 1  board status, valid the cycle after a strobe.
REQ-011 pl_ack / pc_ack  out  1 / 1  one-cycle pulse: request accepted and board updated.
REQ-012 pl_nak / pc_nak  out  1 / 1  one-cycle pulse: request rejected as illegal.
REQ-013 move_en / move_pos / move_who  out  1 / 4 / 2  one-cycle board write strobe, position, and mover (01 player, 10 computer).
REQ-014 turn  out  2  side allowed to move: 00 none, 01 player, 10 computer.
REQ-015 game_over / result  out  1 / 2  game_over is a level; result is 01 player win, 10 computer win, 11 draw.
REQ-016 timeout  out  1  one-cycle pulse when a turn is forfeited.
REQ-017 pl_score / pc_score  out  SCORE_W / SCORE_W  saturating win counters.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT_PL, WAIT_PC, STROBE, CHECK and OVER.
REQ-019 IDLE or OVER with start=1 -> WAIT_PC if first_pc=1, else WAIT_PL; result SHALL be cleared to 00 on this transition.
REQ-020 In WAIT_PL, turn=01 and pc_req SHALL be ignored (no ack, no nak); in WAIT_PC, turn=10 and pl_req SHALL be ignored.
REQ-021 In WAIT_x with x_req=1, the block SHALL latch pos and mover and go to STROBE next cycle; move_en=1 for exactly one cycle in STROBE.
REQ-022 In STROBE with illegal=1: x_nak pulses, move_en is still asserted (the board self-blocks), and the FSM SHALL return to the same WAIT_x with the timeout counter not reset.
REQ-023 In STROBE with illegal=0: x_ack pulses and the FSM goes to CHECK.
REQ-024 Request-to-ack latency SHALL be 1 cycle: req sampled at cycle n, strobe and ack at cycle n+1.
REQ-025 CHECK with win=1: go to OVER, result=who, and increment the winner's score.
REQ-026 CHECK with win=0 and no_space=1: go to OVER with result=11.
REQ-027 CHECK with neither: go to WAIT of the other side, reloading the timeout counter.
REQ-028 Win SHALL take priority over no_space when both are set in CHECK.
REQ-029 The timeout counter SHALL load TIMEOUT_CYC-1 on entry to WAIT_x and decrement each WAIT_x cycle without a request.
REQ-030 When the timeout counter is 0 with no request: timeout pulses and the turn passes to the other WAIT state with the counter reloaded; a request in the same cycle wins over the timeout.
REQ-031 Scores SHALL saturate at 2^SCORE_W-1 with no wrap.
REQ-032 Scores SHALL persist across games and are cleared only by reset.
REQ-033 game_over=1 exactly in OVER; turn=00 in IDLE, STROBE, CHECK and OVER.
REQ-034 In OVER, requests SHALL be ignored and start SHALL begin a new game.
REQ-035 The board is cleared externally via reset; this block SHALL not clear the board.

Reset
REQ-036 With reset=1 at an edge: state IDLE; all pulses 0; turn=00; result=00; game_over=0; move_pos=0; move_who=00; scores=0; timeout counter=TIMEOUT_CYC-1.
REQ-037 Reset SHALL override every other input, including mid-STROBE or mid-CHECK; any in-flight move is discarded.

Verification
REQ-038 Player wins: start, first_pc=0, alternate moves pl5, pc1, pl3, pc2, pl7 with win=1 and who=01 after the last strobe -> result=01, pl_score=1, game_over=1.
REQ-039 Illegal move: pl_req at pos5 with illegal=1 -> pl_nak for 1 cycle, turn stays 01, no pl_ack; retry at pos6 with illegal=0 -> pl_ack, then turn=10.
REQ-040 Timeout (TIMEOUT_CYC=4): turn=01 and no request for 4 cycles -> timeout pulses once, turn=10.
REQ-041 Draw: 9 legal strobes, then no_space=1 with win=0 -> result=11 and scores unchanged.
REQ-042 Saturation (SCORE_W=2): 4 player wins -> pl_score=3 after the 3rd and 4th wins.
REQ-043 Reset in STROBE: reset asserted with move_en=1 -> next cycle IDLE, all outputs at reset values.
